// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the serial adder sequencer: state encoding,
// default operand width and digit-counter sizing.
package serial_adder_ctrl_pkg;

   localparam int DEF_WIDTH = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Digit counter width: clog2(WIDTH/2), never narrower than one bit.
   function automatic int cnt_w(input int width);
      int n;
      n = width / 2;
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/full_adder_2bit.sv
// Existing 2-bit ripple adder: {c_out,s} = a + b + c_in.
module full_adder_2bit (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       c_in,
   output logic [1:0] s,
   output logic       c_out
);

   assign {c_out, s} = {1'b0, a} + {1'b0, b} + {2'b00, c_in};

endmodule

// File: rtl/serial_adder_ctrl.sv
// Serial WIDTH-bit adder built around full_adder_2bit, one 2-bit digit per clock.
// Define SERIAL_ADD_OVF_EN to compute the signed-overflow flag; otherwise ovf is 0.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int            N    = WIDTH / 2;
   localparam int            CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic [1:0]       s;
   logic             co;

   full_adder_2bit u_fa (
      .a    (a_sh[1:0]),
      .b    (b_sh[1:0]),
      .c_in (carry),
      .s    (s),
      .c_out(co)
   );

   // New digit enters at the top; after N shifts sum_nx holds the full result.
   assign sum_nx = (sum_sh >> 2) | (WIDTH'(s) << (WIDTH - 2));

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         sum    <= '0;
         c_out  <= 1'b0;
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
`ifdef SERIAL_ADD_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               a_sh  <= op_a;
               b_sh  <= op_b;
               carry <= c_in;
               cnt   <= '0;
               busy  <= 1'b1;
               state <= RUN;
            end
         end else begin
            a_sh   <= a_sh >> 2;
            b_sh   <= b_sh >> 2;
            sum_sh <= sum_nx;
            carry  <= co;
            cnt    <= cnt + CW'(1);
            if (cnt == LAST) begin
               sum   <= sum_nx;
               c_out <= co;
`ifdef SERIAL_ADD_OVF_EN
               // a_sh/b_sh[1] are the operand MSBs on the last digit
               ovf   <= (a_sh[1] == b_sh[1]) && (s[1] != a_sh[1]);
`endif
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         end
      end
   end

`ifndef SERIAL_ADD_OVF_EN
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: timeline model checked every cycle plus directed literal checks.
module tb_serial_adder_ctrl;

   localparam int W = 8;
   localparam int N = W / 2;
`ifdef SERIAL_ADD_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic         clk = 1'b0, rst = 1'b1, start = 1'b0, c_in = 1'b0;
   logic [W-1:0] op_a = '0, op_b = '0;
   logic         busy, done, c_out, ovf;
   logic [W-1:0] sum;

   int total = 0, bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .op_a (op_a),
      .op_b (op_b),
      .c_in (c_in),
      .busy (busy),
      .done (done),
      .sum  (sum),
      .c_out(c_out),
      .ovf  (ovf)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Model: an accepted add produces op_a+op_b+c_in exactly N edges later.
   int           m_left = 0;
   logic [W:0]   m_res = '0;
   logic         m_rovf = 1'b0;
   logic         m_done = 1'b0, m_co = 1'b0, m_ovf = 1'b0;
   logic [W-1:0] m_sum = '0;

   always @(posedge clk) begin
      if (rst) begin
         m_left = 0; m_done = 1'b0; m_sum = '0; m_co = 1'b0; m_ovf = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_done = 1'b1;
               {m_co, m_sum} = m_res;
               m_ovf = m_rovf;
            end
         end else if (start) begin
            m_res  = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, c_in};
            m_rovf = OVF_ON && (op_a[W-1] == op_b[W-1]) && (m_res[W-1] != op_a[W-1]);
            m_left = N;
         end
      end
   end

   always @(negedge clk)
      if (chk_en)
         chk("cycle{busy,done,c_out,ovf,sum}", {20'd0, busy, done, c_out, ovf, sum},
             {20'd0, m_left > 0, m_done, m_co, m_ovf, m_sum});

   task automatic wait_done(input string nm, output int n);
      n = 1;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk({nm, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic [W-1:0] es, input logic eco, input logic eovf,
                         input string nm);
      int n;
      @(negedge clk);
      op_a = a; op_b = b; c_in = ci; start = 1'b1;
      @(negedge clk);
      start = 1'b0; op_a = W'($urandom); op_b = W'($urandom); c_in = 1'($urandom);
      wait_done(nm, n);
      chk({nm, "_latency"}, n, N + 1);
      chk({nm, "_sum"}, {24'd0, sum}, {24'd0, es});
      chk({nm, "_cout"}, {31'd0, c_out}, {31'd0, eco});
      chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
   endtask

   initial begin
      int n;
      rst = 1'b1;
      @(posedge clk); #1 chk_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_sum", {24'd0, sum}, 32'h00);
      chk("reset_cout_ovf", {30'd0, c_out, ovf}, 32'd0);

      do_add(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0, "basic");
      do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ripple");
      do_add(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "ripple_cin");
      do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, OVF_ON, "ovf_pos");
      do_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, OVF_ON, "ovf_neg");

      // start held through RUN with wandering operands; restart during done cycle
      @(negedge clk);
      op_a = 8'h11; op_b = 8'h22; c_in = 1'b0; start = 1'b1;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (done) break;
         op_a = W'($urandom); op_b = W'($urandom); c_in = 1'($urandom);
      end
      chk("hold_latency", n, N + 1);
      chk("hold_sum", {24'd0, sum}, 32'h33);
      op_a = 8'h10; op_b = 8'h20; c_in = 1'b0;
      @(negedge clk);
      start = 1'b0;
      wait_done("b2b", n);
      chk("b2b_latency", n, N + 1);
      chk("b2b_sum", {24'd0, sum}, 32'h30);

      // reset at the second RUN edge aborts the add
      @(negedge clk);
      op_a = 8'h12; op_b = 8'h34; c_in = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_sum", {24'd0, sum}, 32'h00);
      n = 0;
      repeat (8) begin
         @(negedge clk);
         if (done) n++;
      end
      chk("abort_no_done", n, 0);
      do_add(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after_abort");

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Multi-cycle operand sequencer wrapped around the team's existing 2-bit ripple adder (full_adder_2bit).
- Adds two WIDTH-bit operands two bits per clock: it feeds the adder one digit at a time, captures each 2-bit sum, and carries c_out into the next digit.
- Sits between operand sources (switch/register front end) and result consumers (display/register file). It uses a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and sum width in bits. Must be even and >= 2. Digit count N = WIDTH/2.

Ports:
- clk  input  1  rising-edge system clock
- rst  input  1  synchronous active-high reset
- start  input  1  request an add. Sampled only when not busy.
- op_a  input  WIDTH  operand A, captured on an accepted start
- op_b  input  WIDTH  operand B, captured on an accepted start
- c_in  input  1  carry-in, captured on an accepted start
- busy  output  1  high while a digit sequence is in progress
- done  output  1  one-cycle pulse when sum/c_out are updated
- sum  output  WIDTH  registered result. Holds until the next completion.
- c_out  output  1  registered carry-out of the MSB digit
- ovf  output  1  registered signed-overflow flag (see Optional Feature)

Behaviour:
- Reset: one clock edge with rst=1 forces:
  - state=IDLE
  - busy=0, done=0, sum=0, c_out=0, ovf=0
  - internal shift registers, carry register and digit counter = 0
- rst mid-operation aborts the add. No done pulse follows.
- States:
  - IDLE: busy=0. On an edge with start=1: capture op_a, op_b into shift registers a_sh, b_sh; carry register <= c_in; digit counter <= 0; go to RUN.
  - RUN: busy=1. Combinationally feed the adder a_sh[1:0], b_sh[1:0] and the carry register. Each edge:
    - shift the adder's 2-bit s into the top of sum_sh; sum_sh, a_sh and b_sh shift right by 2
    - carry register <= adder c_out
    - counter increments
  - End of RUN: on the edge where counter == N-1, load sum <= final sum_sh, c_out <= adder c_out and ovf; pulse done; return to IDLE.
- Timing: start accepted at edge k → busy high from after edge k until after edge k+N. done is high for exactly the cycle after edge k+N. busy and done are never high together.
- Back-to-back: start high during the done cycle is accepted (state is IDLE). The next result appears N+1 edges later.
- start while busy is ignored, not queued. op_a, op_b and c_in may change freely after acceptance.
- sum, c_out and ovf change only on the done edge or on reset. They are stable during RUN.
- Arithmetic: {c_out,sum} = op_a + op_b + c_in, modulo 2^(WIDTH+1). No truncation beyond that.
- WIDTH=2 (N=1): RUN lasts one edge, and done follows start by 2 edges.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN
- Defined: on the final digit, ovf = (a_msb == b_msb) && (s_msb != a_msb), using the MSB digit's operand bits and adder sum bit 1. ovf is registered with sum.
- Undefined: ovf is tied to 0 and no overflow logic is synthesised. The port remains present.

Decomposition:
- Shared package/header:
  - state encoding localparams (IDLE=1'b0, RUN=1'b1)
  - default WIDTH
  - counter width = clog2(WIDTH/2), minimum 1
- One sub-module: the existing full_adder_2bit, instantiated once. There is no other hierarchy.

Test Plan:
- Reset/idle: rst high 2 cycles, then start=0 → busy=0, done=0, sum=0x00, c_out=0, ovf=0.
- Basic add (WIDTH=8): op_a=0x35, op_b=0x4A, c_in=0, start at edge k → done only in the cycle after edge k+4; sum=0x7F; c_out=0; busy high exactly 4 cycles.
- Full carry ripple: 0xFF + 0x01, c_in=0 → sum=0x00, c_out=1. 0xFF + 0x00 with c_in=1 → sum=0x00, c_out=1.
- Overflow (macro defined): 0x7F + 0x01 → sum=0x80, ovf=1, c_out=0. 0x80 + 0x80 → sum=0x00, c_out=1, ovf=1. With the macro undefined, ovf=0 in both cases.
- Handshake: start held high and operands changed during RUN → no restart, result matches the captured operands. start during the done cycle with 0x10+0x20 → second done 5 edges later, sum=0x30.
- Reset mid-op: assert rst at the 2nd RUN edge of 0x12+0x34 → no done pulse, outputs 0. A new start then completes normally.
